// File: rtl/knn_vote.sv
// knn_vote -- k-nearest-neighbour majority vote.
//
// After an upstream sorter has ranked the training points, this block walks
// ranks 0..k-1 through the sorter's SEL port. For each rank it looks up the
// class label of the returned neighbour index in an on-chip label memory and
// adds a weight to that class's vote counter. It then scans every class in
// ascending order and reports the class with the most votes. Ties go to the
// lowest class number.
//
// Build option: define KNN_VOTE_WEIGHT_EN to weight rank n by (k - n), so the
// nearest neighbour counts most. When it is undefined, every rank counts 1.
//
// Ports
//   clk        clock; all state changes on its rising edge
//   rst        synchronous active-high reset (label memory is not cleared)
//   lbl_we     label-memory write enable (accepted in any state)
//   lbl_addr   label-memory write address (training-point index)
//   lbl_wdata  label to store
//   start      one-cycle classify request; ignored unless idle
//   k_num      neighbours to vote; clamped to 1..10
//   sel        rank select to the sorter
//   idx_in     neighbour index from the sorter for the current sel
//   busy       high while a classification is in progress (through done)
//   done       one-cycle completion pulse
//   class_out  winning class; held until the next completion or reset
//   votes_out  vote total of the winning class; held likewise
module knn_vote #(
    parameter int IDX_W = 8,
    parameter int LBL_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             lbl_we,
    input  logic [IDX_W-1:0] lbl_addr,
    input  logic [LBL_W-1:0] lbl_wdata,
    input  logic             start,
    input  logic [3:0]       k_num,
    output logic [3:0]       sel,
    input  logic [IDX_W-1:0] idx_in,
    output logic             busy,
    output logic             done,
    output logic [LBL_W-1:0] class_out,
    output logic [5:0]       votes_out
);

    localparam int NCLS  = 1 << LBL_W;
    localparam int DEPTH = 1 << IDX_W;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_ACC,
        S_SCAN,
        S_DONE
    } state_t;

    state_t state_reg, state_next;

    logic [3:0]        k_reg, n_reg;
    logic [3:0]        k_clamped;
    logic [LBL_W-1:0]  scan_reg;
    logic [LBL_W-1:0]  best_class_reg, class_reg;
    logic [5:0]        best_votes_reg, votes_reg;
    logic [LBL_W-1:0]  rd_label_reg;
    logic [NCLS*6-1:0] vote_flat;
    logic [5:0]        weight;
    logic [5:0]        scan_votes;
    logic              scan_better;
    logic              last_rank;
    logic              last_class;
    logic              clear_votes;

    // Label memory: synchronous write, registered read. A read and a write
    // to the same address in one cycle returns the previous contents.
    logic [LBL_W-1:0] lbl_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (lbl_we)
            lbl_mem[lbl_addr] <= lbl_wdata;
        rd_label_reg <= lbl_mem[idx_in];
    end

`ifdef KNN_VOTE_WEIGHT_EN
    // n never reaches k while accumulating, so k - n is always 1..10.
    assign weight = {2'b00, k_reg - n_reg};
`else
    assign weight = 6'd1;
`endif

    always_comb begin
        if (k_num == 4'd0)
            k_clamped = 4'd1;
        else if (k_num > 4'd10)
            k_clamped = 4'd10;
        else
            k_clamped = k_num;
    end

    assign last_rank   = ((n_reg + 4'd1) == k_reg);
    assign last_class  = &scan_reg;
    assign clear_votes = (state_reg == S_IDLE) && start;

    // One 6-bit counter per class. The worst case is 55 (weighted, k = 10),
    // which still fits in 6 bits.
    generate
        for (genvar gi = 0; gi < NCLS; gi++) begin : g_vote
            logic [5:0] cnt_reg;
            always_ff @(posedge clk) begin
                if (rst || clear_votes)
                    cnt_reg <= 6'd0;
                else if (state_reg == S_ACC && rd_label_reg == LBL_W'(gi))
                    cnt_reg <= cnt_reg + weight;
            end
            assign vote_flat[gi*6 +: 6] = cnt_reg;
        end
    endgenerate

    assign scan_votes  = vote_flat[scan_reg*6 +: 6];
    // A strict comparison keeps the earlier (lower) class on a tie.
    assign scan_better = (scan_votes > best_votes_reg);

    always_ff @(posedge clk) begin
        if (rst)
            state_reg <= S_IDLE;
        else
            state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        sel        = 4'd0;
        case (state_reg)
            S_IDLE:  if (start) state_next = S_FETCH;
            S_FETCH: begin
                sel        = n_reg;
                state_next = S_ACC;
            end
            S_ACC:   state_next = last_rank ? S_SCAN : S_FETCH;
            S_SCAN:  if (last_class) state_next = S_DONE;
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    assign busy      = (state_reg != S_IDLE);
    assign done      = (state_reg == S_DONE);
    assign class_out = class_reg;
    assign votes_out = votes_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            k_reg          <= 4'd0;
            n_reg          <= 4'd0;
            scan_reg       <= '0;
            best_class_reg <= '0;
            best_votes_reg <= 6'd0;
            class_reg      <= '0;
            votes_reg      <= 6'd0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (start) begin
                        k_reg <= k_clamped;
                        n_reg <= 4'd0;
                    end
                end
                S_ACC: begin
                    n_reg          <= n_reg + 4'd1;
                    scan_reg       <= '0;
                    best_class_reg <= '0;
                    best_votes_reg <= 6'd0;
                end
                S_SCAN: begin
                    scan_reg <= scan_reg + 1'b1;
                    if (scan_better) begin
                        best_class_reg <= scan_reg;
                        best_votes_reg <= scan_votes;
                    end
                    // The last class is folded in here, so the result is
                    // already stable when done rises.
                    if (last_class) begin
                        class_reg <= scan_better ? scan_reg : best_class_reg;
                        votes_reg <= scan_better ? scan_votes : best_votes_reg;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
